// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq
//   Registered one-hot decoder with two modes of operation.
//   Direct mode: a handshaked request selects one output, which stays asserted
//   for HOLD_CYC cycles. A new request may be taken on the final hold cycle,
//   so back-to-back requests produce no zero gap on d_out.
//   Scan mode: the block sweeps through outputs 0..OUT_N-1 on its own. Each
//   index is held for DWELL cycles, and scan_wrap pulses when the sweep wraps
//   back to index 0.
//   All outputs except in_ready come from flops, so d_out is glitch-free.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; when low, the block is forced back to idle
//   mode       0 = direct, 1 = scan
//   in_valid   direct-mode request
//   in_sel     requested output index
//   in_ready   combinational; a request is accepted when in_valid & in_ready
//   d_out      registered one-hot output, or all-zero
//   out_valid  registered, equal to |d_out
//   err        one-cycle pulse after an accepted in_sel >= OUT_N
//   scan_wrap  one-cycle pulse in the first cycle of index 0 after a wrap
module dec_onehot_seq #(
  parameter int SEL_W    = 4,
  parameter int OUT_N    = 16,
  parameter int HOLD_CYC = 1,
  parameter int DWELL    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  output logic             in_ready,
  output logic [OUT_N-1:0] d_out,
  output logic             out_valid,
  output logic             err,
  output logic             scan_wrap
);

  // A single down-counter serves both the hold time and the scan dwell,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (HOLD_CYC > DWELL) ? HOLD_CYC : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);
  localparam logic [SEL_W:0]   OUT_N_W  = (SEL_W + 1)'(OUT_N);
  localparam logic [OUT_N-1:0] ONE      = OUT_N'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] idx, idx_nx;
  logic [OUT_N-1:0] d_nx;
  logic             err_nx;
  logic             wrap_nx;
  logic             cnt_last;
  logic             accept;
  logic             sel_ok;

  // The counter is loaded with the full count, so a value of 1 marks the
  // final cycle of a hold or dwell period.
  assign cnt_last = (cnt == CNT_W'(1));

  // A new request may be taken while idle, or on the last hold cycle so
  // that back-to-back requests chain without a gap.
  assign in_ready = en & ~mode & ((state == IDLE) | ((state == HOLD) & cnt_last));
  assign accept   = in_valid & in_ready;

  // Compare with one extra bit so the check stays correct when
  // OUT_N == 2**SEL_W.
  assign sel_ok   = ({1'b0, in_sel} < OUT_N_W);

  // Next-state and next-output logic.
  // If a scan request and a direct request arrive together, scan has
  // priority; in practice they cannot collide, because in_ready requires
  // mode == 0.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    d_nx     = d_out;
    err_nx   = 1'b0;
    wrap_nx  = 1'b0;

    case (state)
      IDLE: begin
        d_nx = '0;
        if (en & mode) begin
          state_nx = SCAN;
          idx_nx   = '0;
          cnt_nx   = DWELL_LD;
          d_nx     = ONE;
        end else if (accept) begin
          if (sel_ok) begin
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
            d_nx     = ONE << in_sel;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      // A mode change to scan is not acted on here. It takes effect from
      // IDLE once the hold has run to completion.
      HOLD: begin
        if (!en) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          d_nx     = '0;
        end else if (cnt_last) begin
          if (accept && sel_ok) begin
            cnt_nx = HOLD_LD;
            d_nx   = ONE << in_sel;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
            d_nx     = '0;
            err_nx   = accept;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      SCAN: begin
        if (!en || !mode) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
          d_nx     = '0;
        end else if (cnt_last) begin
          cnt_nx = DWELL_LD;
          if (idx == LAST_IDX) begin
            idx_nx  = '0;
            wrap_nx = 1'b1;
          end else begin
            idx_nx = idx + SEL_W'(1);
          end
          d_nx = ONE << idx_nx;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
        d_nx     = '0;
      end
    endcase
  end

  // State and output registers.
  // out_valid is registered from the next value of d_out, so it always
  // matches |d_out in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      d_out     <= d_nx;
      out_valid <= |d_nx;
      err       <= err_nx;
      scan_wrap <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// tb_dec_onehot_seq
//   Testbench for dec_onehot_seq, built with OUT_N=12, HOLD_CYC=3, DWELL=2.
//   The stimulus pushes expected d_out / scan_wrap / err events, each tagged
//   with the cycle in which it should appear. A separate monitor compares
//   every cycle in which the DUT presents an output.
//   No DUT ports beyond the device under test itself.
module tb_dec_onehot_seq;

  localparam int SEL_W    = 4;
  localparam int OUT_N    = 12;
  localparam int HOLD_CYC = 3;
  localparam int DWELL    = 2;
  localparam int PERIOD   = OUT_N * DWELL;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b1;
  logic             en       = 1'b0;
  logic             mode     = 1'b0;
  logic             in_valid = 1'b0;
  logic [SEL_W-1:0] in_sel   = '0;
  logic             in_ready;
  logic [OUT_N-1:0] d_out;
  logic             out_valid;
  logic             err;
  logic             scan_wrap;

  typedef struct {
    int               cyc;
    logic [OUT_N-1:0] d;
    logic             wrap;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   sb_on    = 1'b1;

  // Hand-computed decode table for OUT_N = 12.
  logic [OUT_N-1:0] dec_tab [12] = '{12'h001, 12'h002, 12'h004, 12'h008,
                                     12'h010, 12'h020, 12'h040, 12'h080,
                                     12'h100, 12'h200, 12'h400, 12'h800};

  dec_onehot_seq #(
    .SEL_W(SEL_W),
    .OUT_N(OUT_N),
    .HOLD_CYC(HOLD_CYC),
    .DWELL(DWELL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .in_valid(in_valid),
    .in_sel(in_sel),
    .in_ready(in_ready),
    .d_out(d_out),
    .out_valid(out_valid),
    .err(err),
    .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  // cyc holds the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushHold(input int first, input logic [OUT_N-1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{cyc: first + i, d: d, wrap: 1'b0});
  endtask

  task automatic pushScan(input int first, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{cyc: first + i,
                        d: OUT_N'(1) << ((i / DWELL) % OUT_N),
                        wrap: (i >= PERIOD) && (i % PERIOD == 0)});
  endtask

  // Issues one request on the next edge. A d_exp of zero means an error
  // pulse is expected instead of a d_out.
  task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [OUT_N-1:0] d_exp, input int n_push);
    checkOutput("in_ready_at_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sel   = sel;
    if (d_exp == '0) err_q.push_back(cyc + 1);
    else pushHold(cyc + 1, d_exp, n_push);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: invariants every cycle, plus scoreboard pops whenever the DUT
  // presents d_out or err.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("out_valid_eq_or", 32'(out_valid), 32'(|d_out));
      checkOutput("onehot", 32'($countones(d_out) <= 1), 32'd1);
      if (sb_on) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_d_out", 32'(d_out), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("d_out_cycle", cyc, e.cyc);
            checkOutput("d_out", 32'(d_out), 32'(e.d));
            checkOutput("scan_wrap", 32'(scan_wrap), 32'(e.wrap));
          end
        end else begin
          if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checkOutput("missing_d_out", 32'(d_out), 32'(e.d));
          end
          checkOutput("scan_wrap_idle", 32'(scan_wrap), 32'd0);
        end
        if (err) begin
          if (err_q.size() == 0) checkOutput("unexpected_err", 32'(err), 32'd0);
          else checkOutput("err_cycle", cyc, err_q.pop_front());
        end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
          void'(err_q.pop_front());
          checkOutput("missing_err", 32'(err), 32'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int c0;

    // Reset values.
    #1 rst_n = 1'b0;
    tick(2);
    checkOutput("reset_d_out", 32'(d_out), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_scan_wrap", 32'(scan_wrap), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 1'b0;
    tick();

    // Back-to-back direct decode of every in-range index.
    // in_ready should be high only in the third hold cycle.
    for (int s = 0; s < OUT_N; s++) begin
      applyStimulus(SEL_W'(s), dec_tab[s], HOLD_CYC);
      checkOutput("in_ready_hold1", 32'(in_ready), 32'd0);
      tick();
      checkOutput("in_ready_hold2", 32'(in_ready), 32'd0);
      tick();
    end
    tick();
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);

    // Out-of-range selects, including the OUT_N boundary, then the top index.
    applyStimulus(4'd13, 12'h000, 0);
    applyStimulus(4'd12, 12'h000, 0);
    applyStimulus(4'd15, 12'h000, 0);
    applyStimulus(4'd11, 12'h800, HOLD_CYC);
    tick(2);
    tick();

    // Asynchronous reset in the middle of a hold.
    applyStimulus(4'd8, 12'h100, 2);
    tick(2);
    checkOutput("pre_reset_d_out", 32'(d_out), 32'h100);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_d_out", 32'(d_out), 32'd0);
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
    tick();

    // Switching to scan mode during a hold: the hold completes, there is one
    // idle cycle, then the scan starts at index 0. en is then dropped at the
    // first cycle of index 7.
    applyStimulus(4'd2, 12'h004, HOLD_CYC);
    a    = cyc;
    mode = 1'b1;
    #1;
    checkOutput("in_ready_mode1", 32'(in_ready), 32'd0);
    pushScan(a + 4, 15);
    tick(18);
    en = 1'b0;
    tick();

    // Full scan with wraps, then leave scan mode by clearing mode.
    en = 1'b1;
    c0 = cyc;
    pushScan(c0 + 1, 2 * PERIOD + 4);
    tick(2 * PERIOD + 4);
    mode = 1'b0;
    tick(2);

    // Random traffic; only the invariants are checked here.
    sb_on = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      mode     = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_sel   = SEL_W'($urandom_range(0, 15));
      tick();
    end
    en       = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    tick(2);
    sb_on = 1'b1;
    tick();

    checkOutput("exp_q_drained", exp_q.size(), 32'd0);
    checkOutput("err_q_drained", err_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_onehot_seq.md
# dec_onehot_seq

Parametrised, registered successor to the combinational 4-to-16 decoder. Converts a SEL_W-bit select into a one-hot OUT_N-bit output. Two modes:
- Direct: handshaked request, held for a programmable number of cycles.
- Scan: autonomous sweep across all outputs.

Used wherever a strobed or rotating one-hot enable is needed, e.g. bank selects, row strobes or channel scanning. Output is glitch-free because it comes from flops.

## Interface
- SEL_W, 4, select width; 1..8
- OUT_N, 16, number of outputs; 2 ≤ OUT_N ≤ 2**SEL_W
- HOLD_CYC, 1, cycles a direct-mode output stays asserted; ≥1
- DWELL, 1, cycles per scan position; ≥1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; asynchronous and active-low
- en  in  1  block enable
- mode  in  1  0 = direct, 1 = scan
- in_valid  in  1  direct-mode request
- in_sel  in  SEL_W  requested output index
- in_ready  out  1  request accepted on edge where in_valid & in_ready
- d_out  out  OUT_N  registered one-hot output (or all-zero)
- out_valid  out  1  registered, equals |d_out
- err  out  1  1-cycle pulse: accepted in_sel ≥ OUT_N
- scan_wrap  out  1  1-cycle pulse on scan wrap to index 0

## Operation
- States: IDLE, HOLD, SCAN. Internal down-counter sized for max(HOLD_CYC, DWELL); scan index counter sized to SEL_W bits.
- Reset (async, rst_n=0): state IDLE, d_out=0, out_valid=0, err=0, scan_wrap=0, counters 0. Any reset mid-operation aborts immediately. Requests are ignored while rst_n=0.
- in_ready is combinational: en & ~mode & (state==IDLE | (state==HOLD & hold counter on final cycle)).

IDLE:
- d_out=0.
- Accepted request with in_sel < OUT_N: d_out ← 1<<in_sel, hold counter ← HOLD_CYC, go HOLD.
- Accepted request with in_sel ≥ OUT_N: err pulses next cycle, d_out stays 0, remain IDLE.
- en & mode: go SCAN with index 0; d_out ← bit 0; no scan_wrap on entry.

HOLD:
- d_out held. Counter decrements each cycle.
- On the final cycle:
  - If a new request is accepted, d_out loads the new one-hot with no zero gap and the counter reloads.
  - Otherwise d_out ← 0 and state returns to IDLE.
- A mode change to 1 during HOLD is deferred until HOLD completes.

SCAN:
- Each index is held DWELL cycles, then the index advances.
- After index OUT_N-1, the index wraps to 0 and scan_wrap pulses in the first cycle of index 0.
- Indices ≥ OUT_N are never driven.

Exits and invariant:
- en=0 in any state: next cycle state IDLE, d_out=0. This aborts HOLD or SCAN; no err or wrap pulse.
- mode=0 during SCAN: next cycle IDLE, d_out=0.
- Invariant: d_out is always zero or exactly one-hot. out_valid == |d_out every cycle.

## Timing
- Direct latency: request accepted at edge k → d_out asserted cycles k+1 … k+HOLD_CYC. Throughput is 1 request per HOLD_CYC cycles with back-to-back requests.
- err asserts exactly in cycle k+1 for one cycle.
- Scan period is OUT_N×DWELL cycles. scan_wrap has the same period, first occurring OUT_N×DWELL cycles after SCAN entry.
- All outputs except in_ready are registered. No combinational path from inputs to d_out, out_valid, err or scan_wrap.

## Test plan
- Reset/idle: assert rst_n=0 mid-HOLD with d_out=16'h0100 → d_out=0, out_valid=0, err=0 immediately (async). After release, IDLE with in_ready=1 when en=1, mode=0.
- Direct decode, defaults: in_sel = 0..15 one per request → d_out = 1<<in_sel for exactly 1 cycle each, back-to-back. HOLD_CYC=3, in_sel=5 → d_out=16'h0020 for 3 cycles, in_ready high only in the 3rd.
- Out-of-range: OUT_N=12, in_sel=13 → err pulse 1 cycle, d_out stays 0. Next request in_sel=11 → d_out=12'h800.
- Scan: OUT_N=12, DWELL=2 → d_out walks 12'h001 … 12'h800, 2 cycles each. scan_wrap pulses every 24 cycles, not at entry. Bits 12–15 never drive.
- Mode/enable interaction: mode 0→1 during HOLD → HOLD finishes, then SCAN starts at index 0. en dropped during SCAN at index 7 → d_out=0 next cycle, no wrap pulse.
- Invariant check: randomised en/mode/in_valid/in_sel for 10k cycles → d_out always zero or one-hot, out_valid==|d_out.
